// File: rtl/axis_conv_input_join.sv
// N-way stream joiner: COPIES pixel streams plus one weight stream are buffered in
// 2-entry FIFOs and merged into one registered AXI-Stream beat with combined TUSER.

module axis_conv_input_join_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = count[1];
   assign empty = (count == 2'd0);
endmodule

module axis_conv_input_join #(
   parameter int COPIES          = 2,
   parameter int WORD_WIDTH      = 8,
   parameter int UNITS           = 8,
   parameter int CORES           = 4,
   parameter int MEMBERS         = 8,
   parameter int TUSER_PIX_WIDTH = 3,
   parameter int TUSER_W_WIDTH   = 12,
   parameter int BEAT_CNT_WIDTH  = 16
) (
   input  logic                                     aclk,
   input  logic                                     aresetn,
   input  logic [COPIES-1:0]                        s_axis_pixels_tvalid,
   output logic [COPIES-1:0]                        s_axis_pixels_tready,
   input  logic [COPIES*WORD_WIDTH*UNITS-1:0]       s_axis_pixels_tdata,
   input  logic [COPIES*TUSER_PIX_WIDTH-1:0]        s_axis_pixels_tuser,
   input  logic                                     s_axis_weights_tvalid,
   output logic                                     s_axis_weights_tready,
   input  logic                                     s_axis_weights_tlast,
   input  logic [WORD_WIDTH*CORES*MEMBERS-1:0]      s_axis_weights_tdata,
   input  logic [TUSER_W_WIDTH-1:0]                 s_axis_weights_tuser,
   output logic                                     m_axis_tvalid,
   input  logic                                     m_axis_tready,
   output logic                                     m_axis_tlast,
   output logic [COPIES*WORD_WIDTH*UNITS-1:0]       m_axis_pixels_tdata,
   output logic [WORD_WIDTH*CORES*MEMBERS-1:0]      m_axis_weights_tdata,
   output logic [TUSER_W_WIDTH+TUSER_PIX_WIDTH-1:0] m_axis_tuser,
   input  logic [COPIES-1:0]                        copy_en,
   input  logic                                     clear_err,
   output logic                                     err_user_mismatch,
   output logic [BEAT_CNT_WIDTH-1:0]                beat_count
);
   localparam int PIX_W = WORD_WIDTH * UNITS;
   localparam int WGT_W = WORD_WIDTH * CORES * MEMBERS;
   localparam int PE_W  = PIX_W + TUSER_PIX_WIDTH;
   localparam int WE_W  = WGT_W + TUSER_W_WIDTH + 1;

   // Handshake: a transfer happens on a rising edge where tvalid && tready; tready
   // depends only on FIFO/mask registers (gated by reset), never on tvalid.
   logic [COPIES-1:0]       act;
   logic [COPIES-1:0]       pix_full;
   logic [COPIES-1:0]       pix_empty;
   logic [COPIES-1:0]       pix_push;
   logic [COPIES-1:0]       pix_pop;
   logic [PE_W-1:0]         pix_head [COPIES];
   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic [WE_W-1:0]         w_head;
   logic                    fire;
   logic                    all_empty;
   logic                    pix_ready_all;
   logic                    mismatch;
   logic [COPIES*PIX_W-1:0] pix_join;

   for (genvar i = 0; i < COPIES; i++) begin : g_pix
      assign s_axis_pixels_tready[i] = aresetn & (~act[i] | ~pix_full[i]);
      assign pix_push[i] = s_axis_pixels_tvalid[i] & s_axis_pixels_tready[i] & act[i];
      assign pix_pop[i]  = fire & act[i];

      // A disabled copy's FIFO is held empty, so stale words never survive re-enabling.
      axis_conv_input_join_fifo2 #(.W(PE_W)) u_fifo (
         .clk   (aclk),
         .rst_n (aresetn),
         .flush (~act[i]),
         .push  (pix_push[i]),
         .pop   (pix_pop[i]),
         .din   ({s_axis_pixels_tuser[i*TUSER_PIX_WIDTH +: TUSER_PIX_WIDTH],
                  s_axis_pixels_tdata[i*PIX_W +: PIX_W]}),
         .dout  (pix_head[i]),
         .full  (pix_full[i]),
         .empty (pix_empty[i])
      );
   end

   assign s_axis_weights_tready = aresetn & ~w_full;
   assign w_push = s_axis_weights_tvalid & s_axis_weights_tready;

   axis_conv_input_join_fifo2 #(.W(WE_W)) u_wfifo (
      .clk   (aclk),
      .rst_n (aresetn),
      .flush (1'b0),
      .push  (w_push),
      .pop   (fire),
      .din   ({s_axis_weights_tlast, s_axis_weights_tuser, s_axis_weights_tdata}),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_comb begin
      pix_ready_all = 1'b1;
      mismatch      = 1'b0;
      pix_join      = '0;
      for (int i = 0; i < COPIES; i++) begin
         if (act[i]) begin
            if (pix_empty[i]) pix_ready_all = 1'b0;
            pix_join[i*PIX_W +: PIX_W] = pix_head[i][PIX_W-1:0];
            if (pix_head[i][PE_W-1:PIX_W] != pix_head[0][PE_W-1:PIX_W]) mismatch = 1'b1;
         end
      end
      fire      = !w_empty && pix_ready_all && (!m_axis_tvalid || m_axis_tready);
      all_empty = w_empty && (&pix_empty) && !m_axis_tvalid;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         act                  <= '1;
         m_axis_tvalid        <= 1'b0;
         m_axis_tlast         <= 1'b0;
         m_axis_tuser         <= '0;
         m_axis_pixels_tdata  <= '0;
         m_axis_weights_tdata <= '0;
         err_user_mismatch    <= 1'b0;
         beat_count           <= '0;
      end else begin
         if (all_empty) act <= copy_en | COPIES'(1);
         if (fire) begin
            m_axis_tvalid        <= 1'b1;
            m_axis_tlast         <= w_head[WE_W-1];
            m_axis_tuser         <= {w_head[WGT_W +: TUSER_W_WIDTH], pix_head[0][PIX_W +: TUSER_PIX_WIDTH]};
            m_axis_pixels_tdata  <= pix_join;
            m_axis_weights_tdata <= w_head[WGT_W-1:0];
         end else if (m_axis_tready) begin
            m_axis_tvalid        <= 1'b0;
            m_axis_tlast         <= 1'b0;
            m_axis_tuser         <= '0;
            m_axis_pixels_tdata  <= '0;
            m_axis_weights_tdata <= '0;
         end
         if (fire && mismatch) err_user_mismatch <= 1'b1;
         else if (clear_err)   err_user_mismatch <= 1'b0;
         if (m_axis_tvalid && m_axis_tready)
            beat_count <= m_axis_tlast ? '0 : beat_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_axis_conv_input_join.sv
// Directed-sequence bench for axis_conv_input_join with randomized beats checked
// against queue-based expectations of the joined stream.

module tb_axis_conv_input_join;
   localparam int PIX_W = 64;
   localparam int WGT_W = 256;
   localparam int PE_W  = 67;
   localparam int WE_W  = 269;

   logic           aclk = 1'b0;
   logic           aresetn;
   logic [1:0]     s_axis_pixels_tvalid;
   logic [1:0]     s_axis_pixels_tready;
   logic [127:0]   s_axis_pixels_tdata;
   logic [5:0]     s_axis_pixels_tuser;
   logic           s_axis_weights_tvalid;
   logic           s_axis_weights_tready;
   logic           s_axis_weights_tlast;
   logic [255:0]   s_axis_weights_tdata;
   logic [11:0]    s_axis_weights_tuser;
   logic           m_axis_tvalid;
   logic           m_axis_tready;
   logic           m_axis_tlast;
   logic [127:0]   m_axis_pixels_tdata;
   logic [255:0]   m_axis_weights_tdata;
   logic [14:0]    m_axis_tuser;
   logic [1:0]     copy_en;
   logic           clear_err;
   logic           err_user_mismatch;
   logic [15:0]    beat_count;

   always #5 aclk = ~aclk;

   axis_conv_input_join dut (
      .aclk                  (aclk),
      .aresetn               (aresetn),
      .s_axis_pixels_tvalid  (s_axis_pixels_tvalid),
      .s_axis_pixels_tready  (s_axis_pixels_tready),
      .s_axis_pixels_tdata   (s_axis_pixels_tdata),
      .s_axis_pixels_tuser   (s_axis_pixels_tuser),
      .s_axis_weights_tvalid (s_axis_weights_tvalid),
      .s_axis_weights_tready (s_axis_weights_tready),
      .s_axis_weights_tlast  (s_axis_weights_tlast),
      .s_axis_weights_tdata  (s_axis_weights_tdata),
      .s_axis_weights_tuser  (s_axis_weights_tuser),
      .m_axis_tvalid         (m_axis_tvalid),
      .m_axis_tready         (m_axis_tready),
      .m_axis_tlast          (m_axis_tlast),
      .m_axis_pixels_tdata   (m_axis_pixels_tdata),
      .m_axis_weights_tdata  (m_axis_weights_tdata),
      .m_axis_tuser          (m_axis_tuser),
      .copy_en               (copy_en),
      .clear_err             (clear_err),
      .err_user_mismatch     (err_user_mismatch),
      .beat_count            (beat_count)
   );

   int checks   = 0;
   int failures = 0;

   // Pending source beats and the scoreboard's accepted-but-not-yet-output beats.
   logic [PE_W-1:0] src_p0[$], src_p1[$], pix_q0[$], pix_q1[$];
   logic [WE_W-1:0] src_w[$], w_q[$];
   logic [1:0]      mask;
   logic            err_model;
   logic [15:0]     bc_model;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic gen(input int n, input int mm_idx, input bit garbage1);
      for (int k = 0; k < n; k++) begin
         logic [PIX_W-1:0] d0, d1;
         logic [2:0]       u0, u1;
         logic [WGT_W-1:0] wd;
         logic [11:0]      wu;
         d0 = {$urandom, $urandom};
         d1 = {$urandom, $urandom};
         u0 = 3'($urandom_range(0, 7));
         u1 = u0;
         if (k == mm_idx) begin
            u0 = 3'b001;
            u1 = 3'b010;
         end
         if (garbage1) u1 = 3'($urandom_range(0, 7));
         for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom;
         wu = 12'($urandom_range(0, 4095));
         src_p0.push_back({u0, d0});
         src_p1.push_back({u1, d1});
         src_w.push_back({(k == n - 1), wu, wd});
      end
   endtask

   task automatic run(input int w_delay, input int stall_len, input bit rnd, input bit check_lat);
      int cyc = 0;
      int first_val = -1;
      bit done = 1'b0;
      bit prev_hold = 1'b0;
      bit pv0, pv1, wv;
      logic [PE_W-1:0] e0, e1;
      logic [WE_W-1:0] ew;
      while (!done && cyc < 2000) begin
         pv0 = (src_p0.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
         pv1 = (src_p1.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
         wv  = (src_w.size() > 0) && (cyc >= w_delay) && (!rnd || $urandom_range(0, 3) != 0);
         e0 = pv0 ? src_p0[0] : '0;
         e1 = pv1 ? src_p1[0] : '0;
         ew = wv ? src_w[0] : '0;
         s_axis_pixels_tvalid  = {pv1, pv0};
         s_axis_pixels_tdata   = {e1[63:0], e0[63:0]};
         s_axis_pixels_tuser   = {e1[66:64], e0[66:64]};
         s_axis_weights_tvalid = wv;
         s_axis_weights_tdata  = ew[255:0];
         s_axis_weights_tuser  = ew[267:256];
         s_axis_weights_tlast  = ew[268];
         m_axis_tready = (cyc >= stall_len) && (!rnd || $urandom_range(0, 2) != 0);
         @(negedge aclk);
         if (pv0 && s_axis_pixels_tready[0]) pix_q0.push_back(src_p0.pop_front());
         if (pv1 && s_axis_pixels_tready[1]) begin
            e1 = src_p1.pop_front();
            if (mask[1]) pix_q1.push_back(e1);
         end
         if (wv && s_axis_weights_tready) w_q.push_back(src_w.pop_front());
         if (!mask[1]) chk("mask_rdy1", s_axis_pixels_tready[1], 1'b1);
         if (stall_len == 10 && cyc == 3) chk("skew_pix_rdy", s_axis_pixels_tready, 2'b00);
         if (stall_len == 10 && cyc == 9) begin
            chk("stall_pix_rdy", s_axis_pixels_tready, 2'b00);
            chk("stall_w_rdy", s_axis_weights_tready, 1'b0);
         end
         if (m_axis_tvalid) begin
            if (first_val < 0) first_val = cyc;
            if (pix_q0.size() == 0 || w_q.size() == 0 || (mask[1] && pix_q1.size() == 0)) begin
               checks++;
               failures++;
               $error("FAIL unexpected_beat observed=valid expected=no_pending_beat");
            end else begin
               e0 = pix_q0[0];
               e1 = mask[1] ? pix_q1[0] : '0;
               ew = w_q[0];
               if (!prev_hold && mask[1] && e1[66:64] != e0[66:64]) err_model = 1'b1;
               chk("pix_data", m_axis_pixels_tdata, {e1[63:0], e0[63:0]});
               chk("wgt_data", m_axis_weights_tdata, ew[255:0]);
               chk("tuser", m_axis_tuser, {ew[267:256], e0[66:64]});
               chk("tlast", m_axis_tlast, ew[268]);
               chk("beat_count", beat_count, bc_model);
               chk("err_flag", err_user_mismatch, err_model);
               if (m_axis_tready) begin
                  void'(pix_q0.pop_front());
                  if (mask[1]) void'(pix_q1.pop_front());
                  void'(w_q.pop_front());
                  bc_model = ew[268] ? 16'd0 : bc_model + 16'd1;
               end
            end
         end else begin
            chk("idle_zero", {m_axis_tlast, m_axis_tuser, m_axis_weights_tdata, m_axis_pixels_tdata}, '0);
         end
         prev_hold = m_axis_tvalid && !m_axis_tready;
         done = (src_p0.size() == 0) && (!mask[1] || src_p1.size() == 0) && (src_w.size() == 0)
                && (pix_q0.size() == 0) && (pix_q1.size() == 0) && (w_q.size() == 0);
         cyc++;
         step();
      end
      s_axis_pixels_tvalid  = 2'b00;
      s_axis_weights_tvalid = 1'b0;
      s_axis_weights_tlast  = 1'b0;
      m_axis_tready         = 1'b1;
      if (!done) chk("drain_timeout", cyc, 0);
      if (check_lat) chk("latency", first_val, 2);
      chk("bc_after_run", beat_count, bc_model);
   endtask

   task automatic drive_beat(input logic [2:0] u0, input logic [2:0] u1, input bit last);
      s_axis_pixels_tvalid  = 2'b11;
      s_axis_pixels_tdata   = {$urandom, $urandom, $urandom, $urandom};
      s_axis_pixels_tuser   = {u1, u0};
      s_axis_weights_tvalid = 1'b1;
      for (int j = 0; j < 8; j++) s_axis_weights_tdata[j*32 +: 32] = $urandom;
      s_axis_weights_tuser  = 12'($urandom_range(0, 4095));
      s_axis_weights_tlast  = last;
   endtask

   task automatic idle_inputs();
      s_axis_pixels_tvalid  = 2'b00;
      s_axis_weights_tvalid = 1'b0;
      s_axis_weights_tlast  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0;
      idle_inputs();
      s_axis_pixels_tdata  = '0;
      s_axis_pixels_tuser  = '0;
      s_axis_weights_tdata = '0;
      s_axis_weights_tuser = '0;
      m_axis_tready = 1'b1;
      copy_en       = 2'b11;
      clear_err     = 1'b0;
      mask          = 2'b11;
      err_model     = 1'b0;
      bc_model      = 16'd0;
      #1;
      chk("rst_pix_rdy", s_axis_pixels_tready, 2'b00);
      chk("rst_w_rdy", s_axis_weights_tready, 1'b0);
      step();
      step();
      chk("rst_out_zero", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_weights_tdata, m_axis_pixels_tdata}, '0);
      chk("rst_bc", beat_count, 16'd0);
      chk("rst_err", err_user_mismatch, 1'b0);
      aresetn = 1'b1;
      #1;
      chk("post_rst_pix_rdy", s_axis_pixels_tready, 2'b11);
      chk("post_rst_w_rdy", s_axis_weights_tready, 1'b1);
      step();

      // basic join: 4 beats, latency and beat_count sequence
      gen(4, -1, 1'b0);
      run(0, 0, 1'b0, 1'b1);

      // weights 5 cycles late, output stalled for 10 cycles
      gen(6, -1, 1'b0);
      run(5, 10, 1'b0, 1'b0);

      // copy 1 masked off and driving garbage
      copy_en = 2'b01;
      mask    = 2'b01;
      step();
      step();
      gen(5, -1, 1'b1);
      run(0, 0, 1'b0, 1'b0);
      src_p1.delete();
      copy_en = 2'b11;
      mask    = 2'b11;
      step();
      step();

      // tuser mismatch on beat 2, then clear, then clear coincident with a new mismatch
      gen(3, 1, 1'b0);
      run(0, 0, 1'b0, 1'b0);
      chk("err_sticky", err_user_mismatch, 1'b1);
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      err_model = 1'b0;
      chk("err_cleared", err_user_mismatch, 1'b0);
      drive_beat(3'b001, 3'b010, 1'b1);
      step();
      idle_inputs();
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      chk("err_set_wins", err_user_mismatch, 1'b1);
      chk("coinc_valid", m_axis_tvalid, 1'b1);
      step();
      chk("coinc_done", m_axis_tvalid, 1'b0);
      chk("coinc_bc", beat_count, 16'd0);

      // reset with one beat in the output register and one in the FIFOs
      drive_beat(3'b100, 3'b100, 1'b0);
      step();
      drive_beat(3'b100, 3'b100, 1'b0);
      step();
      drive_beat(3'b100, 3'b100, 1'b0);
      step();
      idle_inputs();
      m_axis_tready = 1'b0;
      step();
      chk("pre_rst_valid", m_axis_tvalid, 1'b1);
      chk("pre_rst_bc", beat_count, 16'd1);
      chk("pre_rst_err", err_user_mismatch, 1'b1);
      aresetn = 1'b0;
      #1;
      chk("mid_rst_pix_rdy", s_axis_pixels_tready, 2'b00);
      chk("mid_rst_w_rdy", s_axis_weights_tready, 1'b0);
      step();
      chk("mid_rst_out_zero", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_weights_tdata, m_axis_pixels_tdata}, '0);
      chk("mid_rst_bc", beat_count, 16'd0);
      chk("mid_rst_err", err_user_mismatch, 1'b0);
      aresetn = 1'b1;
      #1;
      chk("mid_rst_rdy_back", {s_axis_pixels_tready, s_axis_weights_tready}, 3'b111);
      m_axis_tready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("no_stale", m_axis_tvalid, 1'b0);
      end
      err_model = 1'b0;
      bc_model  = 16'd0;

      // randomized valid/ready traffic after recovery
      gen(8, -1, 1'b0);
      run(0, 0, 1'b1, 1'b0);
      gen(10, 4, 1'b0);
      run(2, 3, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axis_conv_input_join.md
# axis_conv_input_join

Parametrised N-way stream joiner between the image shift buffers / weight rotator and the conv engine. It synchronises COPIES pixel streams and one weight stream into a single AXI-Stream beat with merged TUSER. Unlike the previous combinational join, every input has a 2-entry skid FIFO and the output is fully registered, so there is no combinational ready/valid path. It adds a per-copy enable mask, a TUSER consistency check across copies and a per-packet beat counter.

## Interface
- COPIES, 2: pixel streams joined, 1..4
- WORD_WIDTH, 8: bits per word
- UNITS, 8: pixel words per copy
- CORES, 4; MEMBERS, 8: weight words per beat = CORES*MEMBERS
- TUSER_PIX_WIDTH, 3: pixel-side TUSER bits (is_not_max, is_max, is_lrelu)
- TUSER_W_WIDTH, 12: weight-side TUSER bits
- BEAT_CNT_WIDTH, 16: beat counter width
- aclk  in  1  clock
- aresetn  in  1  reset. One clock; reset is synchronous and active-low.
- s_axis_pixels_tvalid  in  COPIES  per-copy valid
- s_axis_pixels_tready  out  COPIES  per-copy ready
- s_axis_pixels_tdata  in  COPIES*WORD_WIDTH*UNITS  copy i at slice i
- s_axis_pixels_tuser  in  COPIES*TUSER_PIX_WIDTH  copy i at slice i
- s_axis_weights_tvalid / tready / tlast  in/out/in  1  weight handshake and last
- s_axis_weights_tdata  in  WORD_WIDTH*CORES*MEMBERS  weights
- s_axis_weights_tuser  in  TUSER_W_WIDTH  weight flags
- m_axis_tvalid / tready / tlast  out/in/out  1  joined handshake and last
- m_axis_pixels_tdata  out  COPIES*WORD_WIDTH*UNITS  joined pixels
- m_axis_weights_tdata  out  WORD_WIDTH*CORES*MEMBERS  joined weights
- m_axis_tuser  out  TUSER_W_WIDTH+TUSER_PIX_WIDTH  {weight tuser, pixel tuser}
- copy_en  in  COPIES  copy enable mask; bit 0 is forced to 1 internally
- clear_err  in  1  clears err_user_mismatch
- err_user_mismatch  out  1  sticky mismatch flag
- beat_count  out  BEAT_CNT_WIDTH  output beats in the current packet

## Operation
- **Input FIFOs.** Each input (COPIES pixel streams plus weights) has a 2-entry FIFO.
  - tready = (count<2). It is derived from registers only.
  - Push on tvalid&&tready.
  - Weight FIFO stores tdata, tuser and tlast. Pixel FIFOs store tdata and tuser.
- **Active mask.** act = registered copy_en | 1.
  - It is reloaded from copy_en only when all FIFOs and the output register are empty; otherwise it holds.
  - For a disabled copy: tready=1, pushes are discarded, and its output slice is 0.
- **Join.** fire = weight FIFO non-empty && every active pixel FIFO non-empty && (!m_axis_tvalid || m_axis_tready).
  - On fire, pop all active FIFOs and the weight FIFO, and load the output register.
- **TUSER merge.**
  - Pixel part comes from copy 0.
  - Weight part is passed through.
  - m_axis_tuser, m_axis_tlast and m_axis_*_tdata are 0 whenever m_axis_tvalid=0.
- **Mismatch check.** On fire, if any active copy's tuser differs from copy 0's, set err_user_mismatch.
  - It is sticky; clear_err clears it.
  - Set wins when set and clear_err occur in the same cycle.
- **Beat counter.** beat_count increments on each output handshake.
  - It goes to 0 on a handshake with m_axis_tlast=1.
  - It wraps modulo 2^BEAT_CNT_WIDTH.

## Timing
- **Reset values.**
  - All FIFOs empty.
  - m_axis_tvalid, m_axis_tlast, m_axis_tuser and all m_axis tdata = 0.
  - s_axis_*_tready = 0 during reset, and 1 in the first cycle after reset deasserts.
  - err_user_mismatch = 0; beat_count = 0; act = all ones.
- **Latency.** Last required input handshake in cycle c gives fire in cycle c+1 and m_axis_tvalid=1 in cycle c+2.
- **Throughput.** One beat per cycle sustained when m_axis_tready=1. Push and pop in the same cycle on a full FIFO keep count at 2; tready stays low that cycle.
- **Output stall.** With m_axis_tready=0, the output register holds all of its outputs stable. Each FIFO fills to 2 and then drops tready the next cycle. No data is lost.
- **Unbalanced arrival.** A stream arriving early waits in its FIFO. It backpressures after 2 beats.
- **Reset mid-operation.** FIFO contents, the output register, the counter and the error flag are discarded in the reset cycle.
- **Mask change.** A copy_en change while data is in flight takes effect only after the pipeline drains.

## Test plan
- **Basic join.** COPIES=2, all enabled, 4 beats per stream, m_axis_tready=1. Expect:
  - 4 output beats, first m_axis_tvalid 2 cycles after the inputs.
  - Data in order; tlast on beat 4; beat_count sequence 1,2,3 then 0.
- **Skew and stall.** Weights arrive 5 cycles after pixels, and m_axis_tready is held 0 for 10 cycles. Expect:
  - Pixel tready drops after 2 pushes and outputs are held stable.
  - After release, all beats arrive in order with none lost.
- **Mask.** copy_en=2'b01, copy 1 driving garbage. Expect copy 1 tready=1 throughout, output slice 1 = 0, and join driven by copy 0 and weights only.
- **Mismatch.** Copy 1 tuser=3'b010 while copy 0 tuser=3'b001 on beat 2. Expect:
  - err_user_mismatch=1 from the cycle after fire, staying set through later beats.
  - clear_err clears it; a clear coincident with a new mismatch leaves it at 1.
- **Reset mid-stream.** Assert aresetn=0 with 2 beats buffered. Expect all outputs 0 and tready 0 during reset, no stale beats afterwards, and beat_count=0.
